// File: rtl/deinterleaver_bus.sv
// QPP turbo de-interleaver: buffers one code block arriving in interleaved
// order (input j holds x[pi(j)]) and re-emits it in natural order.
module deinterleaver_bus #(
  parameter int K_SMALL  = 1056,
  parameter int F1_SMALL = 17,
  parameter int F2_SMALL = 66,
  parameter int K_LARGE  = 6144,
  parameter int F1_LARGE = 263,
  parameter int F2_LARGE = 480,
  parameter int ADDR_W   = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CRC_start,
  input  logic       CRC_blocksize,
  input  logic       CRC_end,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FIN} state_t;

  // Per-size constants: g(0) = f1+f2, g(1) = g(0) + 2*f2, all mod K.
  localparam logic [ADDR_W-1:0] K_S    = ADDR_W'(K_SMALL);
  localparam logic [ADDR_W-1:0] STEP_S = ADDR_W'((2 * F2_SMALL) % K_SMALL);
  localparam logic [ADDR_W-1:0] G0_S   = ADDR_W'((F1_SMALL + F2_SMALL) % K_SMALL);
  localparam logic [ADDR_W-1:0] G1_S   = ADDR_W'((F1_SMALL + 3 * F2_SMALL) % K_SMALL);
  localparam logic [ADDR_W-1:0] K_L    = ADDR_W'(K_LARGE);
  localparam logic [ADDR_W-1:0] STEP_L = ADDR_W'((2 * F2_LARGE) % K_LARGE);
  localparam logic [ADDR_W-1:0] G0_L   = ADDR_W'((F1_LARGE + F2_LARGE) % K_LARGE);
  localparam logic [ADDR_W-1:0] G1_L   = ADDR_W'((F1_LARGE + 3 * F2_LARGE) % K_LARGE);

  // Both operands are already < K, so one conditional subtract is enough.
  function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b,
                                                 input logic [ADDR_W-1:0] k);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) s = s - {1'b0, k};
    return s[ADDR_W-1:0];
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] k_q, step_q, pi_q, g_q, j_q, rd_q;
  logic [ADDR_W-1:0] k_last;

  logic [7:0]        mem [K_LARGE];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  assign k_last  = k_q - ADDR_W'(1);
  assign wr_en   = (state == LOAD) || (state == IDLE && CRC_start);
  assign wr_addr = (state == LOAD) ? pi_q : '0;

  // Buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      k_q        <= '0;
      step_q     <= '0;
      pi_q       <= '0;
      g_q        <= '0;
      j_q        <= '0;
      rd_q       <= '0;
      data_out   <= '0;
      data_ready <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (CRC_start) begin
            k_q    <= CRC_blocksize ? K_L    : K_S;
            step_q <= CRC_blocksize ? STEP_L : STEP_S;
            pi_q   <= CRC_blocksize ? G0_L   : G0_S;
            g_q    <= CRC_blocksize ? G1_L   : G1_S;
            j_q    <= ADDR_W'(1);
            // A block that ends on its own first byte is a framing error.
            err    <= CRC_end;
            state  <= CRC_end ? IDLE : LOAD;
          end
        end
        LOAD: begin
          pi_q <= mod_add(pi_q, g_q, k_q);
          g_q  <= mod_add(g_q, step_q, k_q);
          j_q  <= j_q + ADDR_W'(1);
          if (j_q == k_last) begin
            // Missing end marker is flagged but the block is still delivered.
            if (!CRC_end) err <= 1'b1;
            rd_q  <= '0;
            state <= DRAIN;
          end else if (CRC_end) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        DRAIN: begin
          data_out   <= mem[rd_q];
          data_ready <= 1'b1;
          if (rd_q == k_last) begin
            rd_q  <= '0;
            state <= FIN;
          end else begin
            rd_q <= rd_q + ADDR_W'(1);
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deinterleaver_bus.sv
// Randomized bench for deinterleaver_bus: input bytes come from a plain QPP
// permutation of a known block; every cycle the outputs are checked against it.
module tb_deinterleaver_bus;
  localparam int KS    = 1056;
  localparam int KL    = 6144;
  localparam int NEVER = 1 << 30;

  logic       clk = 1'b0;
  logic       reset, CRC_start, CRC_blocksize, CRC_end;
  logic [7:0] data_in, data_out;
  logic       data_ready, done, err;

  always #5 clk = ~clk;

  deinterleaver_bus dut (
    .clk(clk), .reset(reset), .CRC_start(CRC_start), .CRC_blocksize(CRC_blocksize),
    .CRC_end(CRC_end), .data_in(data_in), .data_out(data_out),
    .data_ready(data_ready), .done(done), .err(err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  // Expectation state, written by the driver, read by the compare process.
  int   drain_start = NEVER, drain_len = 0;
  int   err_clr = NEVER, err_set = NEVER;
  bit   err_old = 1'b0, err_cur = 1'b0, ident = 1'b0;
  logic [7:0] exp_x [KL];
  logic [7:0] hold = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  function automatic int qpp(input int k, input int f1, input int f2, input int j);
    longint v;
    v = (longint'(f1) * j + longint'(f2) * j * j) % k;
    return int'(v);
  endfunction

  // Per-cycle compare, sampled well after the active edge.
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      hold = 8'h00;
      chk("rst_data_out", 32'(data_out), 32'h0);
      chk("rst_data_ready", 32'(data_ready), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
    end else begin
      bit want_rdy, want_done, want_err;
      want_rdy  = (cyc >= drain_start) && (cyc < drain_start + drain_len);
      want_done = (drain_len > 0) && (cyc == drain_start + drain_len);
      want_err  = (cyc >= err_set) ? 1'b1 : (cyc >= err_clr) ? 1'b0 : err_old;
      if (want_rdy) begin
        int idx;
        idx  = cyc - drain_start;
        hold = exp_x[idx];
        if (ident) chk("ident_byte", 32'(data_out), 32'(idx & 255));
      end
      chk("data_ready", 32'(data_ready), 32'(want_rdy));
      chk("data_out", 32'(data_out), 32'(hold));
      chk("done", 32'(done), 32'(want_done));
      chk("err", 32'(err), 32'(want_err));
    end
  end

  // end_at < 0 means CRC_end is never raised; gl_* / rst_at = NEVER disables.
  task automatic run_block(input bit bs, input int end_at, input bit idn,
                           input int gl_load, input int gl_drain, input int rst_at);
    int k, f1, f2, s, nb, end_c;
    k  = bs ? KL : KS;
    f1 = bs ? 263 : 17;
    f2 = bs ? 480 : 66;
    for (int i = 0; i < k; i++) exp_x[i] = idn ? 8'(i) : 8'($urandom);
    @(negedge clk);
    s       = cyc;
    ident   = idn;
    err_old = err_cur;
    err_clr = s + 1;
    if (end_at >= 0 && end_at < k - 1) begin
      err_set   = s + end_at + 1;
      drain_len = 0;
      nb        = end_at + 1;
    end else begin
      err_set     = (end_at < 0) ? s + k : NEVER;
      drain_start = s + k + 1;
      drain_len   = k;
      nb          = k;
    end
    for (int j = 0; j < nb; j++) begin
      if (j > 0) @(negedge clk);
      CRC_start     = (j == 0) || (j == gl_load);
      CRC_blocksize = (j == 0) ? bs : 1'($urandom);
      CRC_end       = (j == end_at);
      data_in       = exp_x[qpp(k, f1, f2, j)];
    end
    @(negedge clk);
    CRC_start = 1'b0;
    CRC_end   = 1'b0;
    data_in   = 8'($urandom);
    err_cur   = (err_set != NEVER);
    if (drain_len > 0) begin
      end_c = drain_start + drain_len + 1;
      while (cyc < end_c) begin
        CRC_start     = (cyc == drain_start + gl_drain);
        CRC_blocksize = 1'($urandom);
        if (cyc == drain_start + rst_at) begin
          reset     = 1'b1;
          drain_len = 0;
          err_set   = NEVER;
          err_clr   = NEVER;
          err_old   = 1'b0;
          err_cur   = 1'b0;
          @(negedge clk);
          reset = 1'b0;
          break;
        end
        @(negedge clk);
      end
      CRC_start = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    CRC_start = 1'b0; CRC_blocksize = 1'b0; CRC_end = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("pi1_small", 32'(qpp(KS, 17, 66, 1)), 32'd83);
    chk("pi2_small", 32'(qpp(KS, 17, 66, 2)), 32'd298);
    chk("pi1_large", 32'(qpp(KL, 263, 480, 1)), 32'd743);
    repeat (2) @(negedge clk);

    run_block(1'b0, KS - 1, 1'b1, NEVER, NEVER, NEVER);  // small, identity pattern
    run_block(1'b1, KL - 1, 1'b1, NEVER, NEVER, NEVER);  // large, identity pattern
    run_block(1'b0, 500,    1'b0, NEVER, NEVER, NEVER);  // early end
    run_block(1'b0, KS - 1, 1'b0, NEVER, NEVER, NEVER);  // recovery clears err
    run_block(1'b0, -1,     1'b0, NEVER, NEVER, NEVER);  // end marker missing
    run_block(1'b0, KS - 1, 1'b0, NEVER, NEVER, 300);    // reset mid-drain
    run_block(1'b0, KS - 1, 1'b0, NEVER, NEVER, NEVER);
    run_block(1'b0, KS - 1, 1'b0, 200,   5,     NEVER);  // stray starts ignored
    for (int r = 0; r < 2; r++)
      run_block(1'b0, KS - 1, 1'b0, $urandom_range(1, KS - 2), $urandom_range(0, KS - 1), NEVER);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
